// File: rtl/flash_reader_pkg.sv
// Shared types and helpers for the flash sample reader: FSM state encoding,
// sample/word widths and the direction-dependent half selector.
package flash_reader_pkg;

    localparam int SAMPLE_W = 16;
    localparam int DATA_W   = 2 * SAMPLE_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_DATA = 3'd2,
        READY     = 3'd3,
        ADV_WAIT  = 3'd4
    } state_t;

    // Forward plays low half first, backward plays high half first.
    function automatic logic [SAMPLE_W-1:0] select_half(
        input logic [DATA_W-1:0] word,
        input logic              dir,
        input logic              half_sel
    );
        return (dir ^ half_sel) ? word[SAMPLE_W-1:0] : word[DATA_W-1:SAMPLE_W];
    endfunction

endpackage

// File: rtl/flash_sample_reader.sv
// Fetches 32-bit words over an Avalon-MM read master and plays them out as two
// 16-bit samples on sample_tick. Optional read timeout: FLASH_READER_TIMEOUT_EN.
module flash_sample_reader #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 32,
    parameter int SAMPLE_W    = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                direction_flag,
    input  logic                sample_tick,
    input  logic [ADDR_W-1:0]   addr_in,
    output logic                addr_adv,
    output logic                flash_read,
    output logic [ADDR_W-1:0]   flash_address,
    input  logic                flash_waitrequest,
    input  logic [DATA_W-1:0]   flash_readdata,
    input  logic                flash_readdatavalid,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                underrun,
`ifdef FLASH_READER_TIMEOUT_EN
    output logic                read_err,
`endif
    output logic                busy
);
    import flash_reader_pkg::*;

    if (DATA_W != 2 * SAMPLE_W || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_cfg
        $error("flash_sample_reader: invalid parameter combination");
    end

    state_t              r_state;
    logic                r_dir_lat;
    logic                r_half_sel;
    logic                r_abort;
    logic [DATA_W-1:0]   r_word;
    logic                w_starved;
`ifdef FLASH_READER_TIMEOUT_EN
    logic [7:0]          r_to_cnt;
`endif

    assign flash_read = (r_state == FETCH);
    assign busy       = (r_state != IDLE);
    assign w_starved  = (r_state == FETCH) || (r_state == WAIT_DATA) || (r_state == ADV_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_dir_lat     <= 1'b0;
            r_half_sel    <= 1'b0;
            r_abort       <= 1'b0;
            r_word        <= '0;
            flash_address <= '0;
            sample_out    <= '0;
            sample_valid  <= 1'b0;
            addr_adv      <= 1'b0;
            underrun      <= 1'b0;
`ifdef FLASH_READER_TIMEOUT_EN
            r_to_cnt      <= '0;
            read_err      <= 1'b0;
`endif
        end else begin
            sample_valid <= 1'b0;
            addr_adv     <= 1'b0;
            if (sample_tick && w_starved)
                underrun <= 1'b1;
`ifdef FLASH_READER_TIMEOUT_EN
            if (r_state != WAIT_DATA)
                r_to_cnt <= '0;
`endif
            case (r_state)
                IDLE: begin
                    if (start) begin
                        flash_address <= addr_in;
                        r_dir_lat     <= direction_flag;
                        r_state       <= FETCH;
                    end
                end
                FETCH: begin
                    // A read in flight must finish even if playback stops.
                    if (!start)
                        r_abort <= 1'b1;
                    if (!flash_waitrequest)
                        r_state <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (flash_readdatavalid) begin
                        if (r_abort || !start) begin
                            r_abort <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_word     <= flash_readdata;
                            r_half_sel <= 1'b0;
                            r_state    <= READY;
                        end
                    end
`ifdef FLASH_READER_TIMEOUT_EN
                    // On timeout the word is zeroed so both halves play silence.
                    else if (r_to_cnt == 8'(TIMEOUT_CYC - 1)) begin
                        read_err   <= 1'b1;
                        r_word     <= '0;
                        r_half_sel <= 1'b0;
                        if (r_abort || !start) begin
                            r_abort <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= READY;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
`endif
                end
                READY: begin
                    if (!start) begin
                        r_state <= IDLE;
                    end else if (sample_tick) begin
                        sample_out   <= select_half(r_word, r_dir_lat, r_half_sel);
                        sample_valid <= 1'b1;
                        if (!r_half_sel) begin
                            r_half_sel <= 1'b1;
                        end else begin
                            addr_adv <= 1'b1;
                            r_state  <= ADV_WAIT;
                        end
                    end
                end
                ADV_WAIT: begin
                    if (!start) begin
                        r_state <= IDLE;
                    end else begin
                        flash_address <= addr_in;
                        r_dir_lat     <= direction_flag;
                        r_state       <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench for flash_sample_reader: a cycle table for the main play path,
// then hand-written stall, underrun, abort, async-reset and timeout sequences.
module tb_flash_sample_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        direction_flag;
    logic        sample_tick;
    logic [5:0]  addr_in;
    logic        addr_adv;
    logic        flash_read;
    logic [5:0]  flash_address;
    logic        flash_waitrequest;
    logic [31:0] flash_readdata;
    logic        flash_readdatavalid;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        underrun;
    logic        busy;
`ifdef FLASH_READER_TIMEOUT_EN
    logic        read_err;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

`ifdef FLASH_READER_TIMEOUT_EN
    flash_sample_reader #(.ADDR_W(6), .DATA_W(32), .SAMPLE_W(16), .TIMEOUT_CYC(8)) dut (
`else
    flash_sample_reader #(.ADDR_W(6), .DATA_W(32), .SAMPLE_W(16)) dut (
`endif
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .direction_flag      (direction_flag),
        .sample_tick         (sample_tick),
        .addr_in             (addr_in),
        .addr_adv            (addr_adv),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid),
        .sample_out          (sample_out),
        .sample_valid        (sample_valid),
        .underrun            (underrun),
`ifdef FLASH_READER_TIMEOUT_EN
        .read_err            (read_err),
`endif
        .busy                (busy)
    );

    typedef struct {
        logic        start;
        logic        dir;
        logic        tick;
        logic [5:0]  addr;
        logic        wreq;
        logic        rdv;
        logic [31:0] rdata;
        logic        rd;
        logic [5:0]  fa;
        logic [15:0] so;
        logic        sv;
        logic        adv;
        logic        und;
        logic        bsy;
    } vec_t;

    vec_t vecs[19];

    function automatic logic [26:0] pack_out(input logic rd, input logic [5:0] fa,
                                             input logic [15:0] so, input logic sv,
                                             input logic adv, input logic und,
                                             input logic bsy);
        return {rd, fa, so, sv, adv, und, bsy};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        logic seen_sv, seen_adv;

        //             start  dir    tick   addr   wreq   rdv    rdata          rd     fa     so        sv     adv    und    bsy
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 6'd3,  1'b0, 1'b0, 32'h0,         1'b1, 6'd3,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 6'd3,  1'b0, 1'b0, 32'h0,         1'b0, 6'd3,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 6'd3,  1'b0, 1'b1, 32'hBBBB_AAAA, 1'b0, 6'd3,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 6'd3,  1'b0, 1'b0, 32'h0,         1'b0, 6'd3,  16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 6'd3,  1'b0, 1'b0, 32'h0,         1'b0, 6'd3,  16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 6'd3,  1'b0, 1'b0, 32'h0,         1'b0, 6'd3,  16'hBBBB, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 6'd10, 1'b0, 1'b0, 32'h0,         1'b1, 6'd10, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 6'd10, 1'b0, 1'b0, 32'h0,         1'b0, 6'd10, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 6'd10, 1'b0, 1'b1, 32'hBBBB_AAAA, 1'b0, 6'd10, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 6'd10, 1'b0, 1'b0, 32'h0,         1'b0, 6'd10, 16'hBBBB, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 6'd10, 1'b0, 1'b0, 32'h0,         1'b0, 6'd10, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 6'd10, 1'b0, 1'b0, 32'h0,         1'b0, 6'd10, 16'hAAAA, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 6'd10, 1'b0, 1'b0, 32'h0,         1'b0, 6'd10, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 6'd10, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 6'd10, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 32'h0,         1'b1, 6'd0,  16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 32'h0,         1'b0, 6'd0,  16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 1'b1, 32'h1234_5678, 1'b0, 6'd0,  16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 6'd0,  1'b0, 1'b0, 32'h0,         1'b0, 6'd0,  16'h5678, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 32'h0,         1'b0, 6'd0,  16'h5678, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b0;
        start = 1'b0;
        direction_flag = 1'b0;
        sample_tick = 1'b0;
        addr_in = '0;
        flash_waitrequest = 1'b0;
        flash_readdata = '0;
        flash_readdatavalid = 1'b0;

        tick_edge();
        tick_edge();
        check("reset_outputs",
              64'(pack_out(flash_read, flash_address, sample_out, sample_valid, addr_adv, underrun, busy)),
              64'(0));
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            start               = vecs[i].start;
            direction_flag      = vecs[i].dir;
            sample_tick         = vecs[i].tick;
            addr_in             = vecs[i].addr;
            flash_waitrequest   = vecs[i].wreq;
            flash_readdatavalid = vecs[i].rdv;
            flash_readdata      = vecs[i].rdata;
            tick_edge();
            check($sformatf("vec%0d", i),
                  64'(pack_out(flash_read, flash_address, sample_out, sample_valid, addr_adv, underrun, busy)),
                  64'(pack_out(vecs[i].rd, vecs[i].fa, vecs[i].so, vecs[i].sv, vecs[i].adv, vecs[i].und, vecs[i].bsy)));
        end
        sample_tick = 1'b0;
        flash_readdatavalid = 1'b0;

        // waitrequest stall: address and read must hold while addr_in moves
        start = 1'b1; direction_flag = 1'b1; addr_in = 6'd7; flash_waitrequest = 1'b1;
        tick_edge();
        addr_in = 6'd9;
        n_acc = 0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("stall_c%0d", c), 64'({flash_read, flash_address}), 64'({1'b1, 6'd7}));
            flash_waitrequest = (c <= 4);
            if (flash_read && !flash_waitrequest) n_acc++;
            tick_edge();
        end
        check("stall_read_drop", 64'(flash_read), 64'(0));

        // tick while waiting for data; data arrives 6 cycles into WAIT_DATA
        sample_tick = 1'b1;
        tick_edge();
        sample_tick = 1'b0;
        seen_sv = sample_valid;
        check("underrun_set", 64'(underrun), 64'(1));
        for (int k = 0; k < 5; k++) begin
            if (flash_read && !flash_waitrequest) n_acc++;
            tick_edge();
            seen_sv |= sample_valid;
        end
        flash_readdata = 32'hCCCC_DDDD;
        flash_readdatavalid = 1'b1;
        tick_edge();
        flash_readdatavalid = 1'b0;
        seen_sv |= sample_valid;
        check("underrun_no_sval", 64'(seen_sv), 64'(0));
        check("single_read", 64'(n_acc), 64'(1));
        sample_tick = 1'b1;
        tick_edge();
        sample_tick = 1'b0;
        check("late_first", 64'({sample_out, sample_valid}), 64'({16'hDDDD, 1'b1}));
        tick_edge();
        sample_tick = 1'b1;
        tick_edge();
        sample_tick = 1'b0;
        check("late_second", 64'({sample_out, sample_valid, addr_adv}), 64'({16'hCCCC, 1'b1, 1'b1}));
        check("underrun_sticky", 64'(underrun), 64'(1));
        start = 1'b0;
        tick_edge();
        check("late_stop", 64'(busy), 64'(0));

        // start dropped in WAIT_DATA: read completes, data discarded
        start = 1'b1; addr_in = 6'd1; flash_waitrequest = 1'b0;
        tick_edge();
        tick_edge();
        start = 1'b0;
        seen_sv = 1'b0;
        seen_adv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick_edge();
            seen_sv |= sample_valid;
            seen_adv |= addr_adv;
        end
        check("abort_hold_busy", 64'(busy), 64'(1));
        flash_readdata = 32'h1111_2222;
        flash_readdatavalid = 1'b1;
        tick_edge();
        flash_readdatavalid = 1'b0;
        seen_sv |= sample_valid;
        seen_adv |= addr_adv;
        check("abort_idle", 64'(busy), 64'(0));
        check("abort_no_pulses", 64'({seen_sv, seen_adv}), 64'(0));
        check("abort_discard", 64'(sample_out), 64'(16'hCCCC));

        // asynchronous reset in the middle of FETCH
        start = 1'b1; addr_in = 6'd5; flash_waitrequest = 1'b1;
        tick_edge();
        check("rst_pre_fetch", 64'({flash_read, flash_address}), 64'({1'b1, 6'd5}));
        #2;
        rst = 1'b0;
        #1;
        check("async_rst",
              64'(pack_out(flash_read, flash_address, sample_out, sample_valid, addr_adv, underrun, busy)),
              64'(0));
        start = 1'b0;
        flash_waitrequest = 1'b0;
        tick_edge();
        rst = 1'b1;

`ifdef FLASH_READER_TIMEOUT_EN
        // no readdatavalid: error after 8 cycles in WAIT_DATA, then silence
        start = 1'b1; direction_flag = 1'b1; addr_in = 6'd2;
        tick_edge();
        tick_edge();
        for (int c = 0; c < 7; c++) tick_edge();
        check("timeout_not_yet", 64'(read_err), 64'(0));
        tick_edge();
        check("timeout_err", 64'(read_err), 64'(1));
        sample_tick = 1'b1;
        tick_edge();
        sample_tick = 1'b0;
        check("timeout_first", 64'({sample_out, sample_valid}), 64'({16'h0000, 1'b1}));
        tick_edge();
        sample_tick = 1'b1;
        tick_edge();
        sample_tick = 1'b0;
        check("timeout_second", 64'({sample_out, sample_valid, addr_adv}), 64'({16'h0000, 1'b1, 1'b1}));
        start = 1'b0;
        tick_edge();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/flash_sample_reader.md
Name: flash_sample_reader

Overview:
- Consumer side of the playback address generator. Takes the current word address and direction flag, and fetches 32-bit words from flash over an Avalon-MM read master.
- Splits each word into two 16-bit audio samples, emitted in direction-dependent order on an audio-rate strobe.
- Requests the next address with a one-cycle advance pulse. Sits between the address counter, the flash controller and the audio output path.

Parameters:
- ADDR_W, 6, width of word address in/out
- DATA_W, 32, flash read data width; fixed at 2*SAMPLE_W
- SAMPLE_W, 16, audio sample width
- TIMEOUT_CYC, 255, max cycles in WAIT_DATA (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  level; playback enable
- direction_flag  in  1  1 = forward, 0 = backward
- sample_tick  in  1  one-cycle strobe; audio sink requests one sample
- addr_in  in  ADDR_W  current word address from the address generator
- addr_adv  out  1  one-cycle pulse; generator steps one address
- flash_read  out  1  Avalon read request
- flash_address  out  ADDR_W  Avalon word address
- flash_waitrequest  in  1  Avalon waitrequest
- flash_readdata  in  DATA_W  Avalon read data
- flash_readdatavalid  in  1  Avalon read data valid
- sample_out  out  SAMPLE_W  current sample, held between updates
- sample_valid  out  1  one-cycle pulse when sample_out updates
- underrun  out  1  sticky; sample_tick arrived while no sample was ready
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; word buffer 0; half_sel 0; dir_lat 0.
- States: IDLE, FETCH, WAIT_DATA, READY, ADV_WAIT.
- IDLE: start=1 -> FETCH. Latch flash_address<=addr_in and dir_lat<=direction_flag on entry.
- FETCH:
  - flash_read=1; flash_address held stable.
  - While flash_waitrequest=1, stay in FETCH.
  - First cycle with waitrequest=0 -> WAIT_DATA; flash_read drops the next cycle.
- WAIT_DATA: on flash_readdatavalid=1, capture flash_readdata, half_sel<=0, -> READY.
- READY, on sample_tick:
  - Forward (dir_lat=1): first sample = bits [15:0], second = [31:16]. Backward: first = [31:16], second = [15:0].
  - sample_out and sample_valid register one cycle after sample_tick (latency 1).
  - After the first half: half_sel<=1, remain READY.
  - After the second half: addr_adv pulses in the same cycle as sample_valid, -> ADV_WAIT.
- ADV_WAIT: exactly one cycle (generator output is registered), then -> FETCH, relatching addr_in and direction_flag.
- Direction change mid-word: takes effect only at the next FETCH latch; the current word completes in its latched order.
- Underrun:
  - sample_tick in FETCH, WAIT_DATA or ADV_WAIT sets underrun=1 (sticky until reset). The tick is dropped; no sample_valid.
  - sample_tick in IDLE is ignored; no underrun.
- start=0:
  - In READY or ADV_WAIT: -> IDLE next cycle; no addr_adv.
  - In FETCH or WAIT_DATA: the outstanding read completes and its data is discarded, then -> IDLE. Never abandon a read with waitrequest pending.
- Wrap-around is owned by the generator; the reader uses addr_in verbatim (e.g. forward 10 -> 0, backward 0 -> 10).
- readdatavalid outside WAIT_DATA: ignored.

Optional Feature:
- Macro FLASH_READER_TIMEOUT_EN.
- Defined: an 8-bit counter runs in WAIT_DATA. On reaching TIMEOUT_CYC without readdatavalid:
  - Set a sticky output port read_err.
  - Load sample_out=0 for both halves, -> READY, so playback continues with silence.
- Undefined: no counter and no read_err port; WAIT_DATA waits indefinitely.

Decomposition:
- Package flash_reader_pkg: state enum typedef (IDLE, FETCH, WAIT_DATA, READY, ADV_WAIT), SAMPLE_W/DATA_W constants, function select_half(word, dir, half_sel).
- No sub-module required; the Avalon handshake stays inline in the FSM.

Test Plan:
- Forward, addr_in=3, readdata=32'hBBBB_AAAA, waitrequest low -> two ticks give sample_out 16'hAAAA then 16'hBBBB, each sample_valid 1 cycle after its tick; addr_adv pulses with the second.
- Backward, same word -> 16'hBBBB then 16'hAAAA; flash_address=3 during FETCH.
- waitrequest held 4 cycles -> flash_read and flash_address stay stable for 5 cycles; exactly one read issued.
- Tick during WAIT_DATA (readdatavalid delayed 6 cycles) -> underrun=1, no sample_valid for that tick; underrun stays 1 after later normal samples.
- start dropped in WAIT_DATA, readdatavalid 3 cycles later -> data discarded, IDLE, no sample_valid, no addr_adv; rst=0 mid-FETCH -> flash_read=0 immediately (async).
- With FLASH_READER_TIMEOUT_EN, TIMEOUT_CYC=8, no readdatavalid -> read_err=1 after 8 cycles; next two ticks output 16'h0000.
